// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the binary-to-BCD scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int DATA_W      = 8;
    localparam int ITER_CNT    = 8;
    localparam int WORK_W      = 3 * BCD_DIGIT_W + DATA_W;
    localparam int CNT_W       = $clog2(ITER_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic                   sign;
        logic [BCD_DIGIT_W-1:0] hundreds;
        logic [BCD_DIGIT_W-1:0] tens;
        logic [BCD_DIGIT_W-1:0] ones;
    } bcd_result_t;

    function automatic logic [BCD_DIGIT_W-1:0] add3_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_shift_add3_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_shift_add3_step
// Brief    : One double-dabble iteration: add-3 correction on each BCD digit,
//            then a 1-bit left shift of the {bcd, bin} working register.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_shift_add3_step
    import bcd_pkg::*;
(
    input  logic [WORK_W-1:0] work_in,
    output logic [WORK_W-1:0] work_out
);

    logic [WORK_W-1:0] w_adj;

    assign w_adj[DATA_W-1:0] = work_in[DATA_W-1:0];

    for (genvar g = 0; g < 3; g++) begin : g_digit
        assign w_adj[DATA_W + g*BCD_DIGIT_W +: BCD_DIGIT_W] =
            add3_digit(work_in[DATA_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    // Hundreds never exceeds 2 for 8-bit input, so the MSB shifted out is always 0.
    assign work_out = w_adj << 1;

endmodule
`default_nettype wire

// File: rtl/bcd_conversion_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conversion_scheduler
// Brief    : Round-robin arbiter sharing one iterative binary-to-BCD converter
//            between two requesters; holds sign/digits for display decoding.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_conversion_scheduler #(
    parameter bit SIGNED_MODE = 1'b1,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    output logic [1:0]        ack,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic              sign,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    import bcd_pkg::*;

    localparam int ONES_LSB = DATA_W;
    localparam int TENS_LSB = DATA_W + BCD_DIGIT_W;
    localparam int HUND_LSB = DATA_W + 2*BCD_DIGIT_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant;
    logic               w_load_result;
    logic               w_gnt_idx;
    logic [DATA_W-1:0]  w_operand;
    logic               w_is_neg;
    logic [DATA_W-1:0]  w_magnitude;
    logic [WORK_W-1:0]  w_work_step;

    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WORK_W-1:0]  r_work;
    logic               r_sign_work;
    logic               r_id_work;
    logic               r_last_grant;
    logic [1:0]         r_ack;
    logic               r_busy;
    logic               r_done;
    logic               r_done_id;
    bcd_result_t        r_result;

    // Tie goes to the requester that did not win last time.
    assign w_gnt_idx = (req == 2'b11) ? ~r_last_grant : req[1];
    assign w_operand = w_gnt_idx ? data_1 : data_0;
    assign w_is_neg  = SIGNED_MODE && w_operand[DATA_W-1];
    // 8 bits suffice: negating 0x80 wraps back to 0x80, which reads as 128 unsigned.
    assign w_magnitude = w_is_neg ? (~w_operand + 1'b1) : w_operand;

    bcd_shift_add3_step u_step (
        .work_in  (r_work),
        .work_out (w_work_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (r_bit_cnt == CNT_W'(ITER_CNT-1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_load_result = 1'b1;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_work       <= '0;
            r_sign_work  <= 1'b0;
            r_id_work    <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack        <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
            r_result     <= '0;
        end else begin
            r_ack  <= 2'b00;
            r_done <= w_load_result;
            // Stays high through the DONE cycle so it drops one edge after done rises.
            r_busy <= w_grant || (r_state != IDLE);

            if (w_grant) begin
                r_ack        <= w_gnt_idx ? 2'b10 : 2'b01;
                r_last_grant <= w_gnt_idx;
                r_id_work    <= w_gnt_idx;
                r_sign_work  <= w_is_neg;
                r_work       <= {{(WORK_W-DATA_W){1'b0}}, w_magnitude};
                r_bit_cnt    <= '0;
            end else if (r_state == CONVERT) begin
                r_work    <= w_work_step;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_load_result) begin
                r_result.sign     <= r_sign_work;
                r_result.hundreds <= r_work[HUND_LSB +: BCD_DIGIT_W];
                r_result.tens     <= r_work[TENS_LSB +: BCD_DIGIT_W];
                r_result.ones     <= r_work[ONES_LSB +: BCD_DIGIT_W];
                r_done_id         <= r_id_work;
            end
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign done     = r_done;
    assign done_id  = r_done_id;
    assign sign     = r_result.sign;
    assign hundreds = r_result.hundreds;
    assign tens     = r_result.tens;
    assign ones     = r_result.ones;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conversion_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_conversion_scheduler
// Brief    : Directed self-checking bench; signed and unsigned instances run
//            in lockstep on shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conversion_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] data_0;
    logic [7:0] data_1;

    logic [1:0] ack_s, ack_u;
    logic       busy_s, busy_u, done_s, done_u, done_id_s, done_id_u, sign_s, sign_u;
    logic [3:0] hundreds_s, tens_s, ones_s, hundreds_u, tens_u, ones_u;
    logic [12:0] res_s, res_u;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign res_s = {sign_s, hundreds_s, tens_s, ones_s};
    assign res_u = {sign_u, hundreds_u, tens_u, ones_u};

    bcd_conversion_scheduler #(.SIGNED_MODE(1'b1), .DATA_W(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .data_0(data_0), .data_1(data_1),
        .ack(ack_s), .busy(busy_s), .done(done_s), .done_id(done_id_s),
        .sign(sign_s), .hundreds(hundreds_s), .tens(tens_s), .ones(ones_s)
    );

    bcd_conversion_scheduler #(.SIGNED_MODE(1'b0), .DATA_W(8)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .req(req), .data_0(data_0), .data_1(data_1),
        .ack(ack_u), .busy(busy_u), .done(done_u), .done_id(done_id_u),
        .sign(sign_u), .hundreds(hundreds_u), .tens(tens_u), .ones(ones_u)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {sign, hundreds, tens, ones} by decimal arithmetic.
    function automatic logic [12:0] ref_bcd(input logic [7:0] d, input bit sm);
        int   mag;
        logic s;
        s   = sm && d[7];
        mag = s ? (256 - int'(d)) : int'(d);
        return {s, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    // Called one step after an edge with both DUTs idle; returns at E10+1.
    task automatic convert(input string tag, input logic [1:0] r, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [1:0] exp_ack, input logic exp_id,
                           input logic [12:0] exp_s, input logic [12:0] exp_u);
        bit ok;
        req    = r;
        data_0 = d0;
        data_1 = d1;
        tick;
        check({tag, " ack"}, ack_s, exp_ack);
        check({tag, " busy at grant"}, busy_s, 1);
        req = 2'b00;
        ok  = 1'b1;
        repeat (8) begin
            tick;
            if (busy_s !== 1'b1 || done_s !== 1'b0 || ack_s !== 2'b00) ok = 1'b0;
        end
        check({tag, " busy/no done in convert"}, ok, 1);
        tick;
        check({tag, " done_s"}, done_s, 1);
        check({tag, " done_u"}, done_u, 1);
        check({tag, " done_id"}, done_id_s, exp_id);
        check({tag, " result signed"}, res_s, exp_s);
        check({tag, " result unsigned"}, res_u, exp_u);
        tick;
        check({tag, " done one cycle"}, done_s, 0);
        check({tag, " busy fall"}, busy_s, 0);
        check({tag, " result held"}, res_s, exp_s);
    endtask

    initial begin
        bit ok;
        rst_n  = 1'b0;
        req    = 2'b00;
        data_0 = 8'h00;
        data_1 = 8'h00;
        repeat (3) tick;
        check("reset ctrl s", {ack_s, busy_s, done_s, done_id_s}, 0);
        check("reset ctrl u", {ack_u, busy_u, done_u, done_id_u}, 0);
        check("reset res s", res_s, 0);
        check("reset res u", res_u, 0);
        rst_n = 1'b1;
        tick;

        // Continuous tie: first tie after reset goes to requester 0.
        req    = 2'b11;
        data_0 = 8'h0C;
        data_1 = 8'h22;
        tick;
        check("tie ack #1", ack_s, 2'b01);
        repeat (9) tick;
        check("tie done #1", done_s, 1);
        check("tie id #1", done_id_s, 0);
        check("tie res #1", res_s, 13'h0012);
        tick;
        check("tie ack #2", ack_s, 2'b10);
        repeat (9) tick;
        check("tie id #2", done_id_s, 1);
        check("tie res #2", res_s, 13'h0034);
        check("tie res #2 u", res_u, 13'h0034);
        tick;
        check("tie ack #3", ack_s, 2'b01);
        req = 2'b00;
        repeat (9) tick;
        check("tie id #3", done_id_s, 0);
        check("tie res #3", res_s, 13'h0012);
        tick;
        check("tie idle busy", busy_s, 0);

        convert("pos7F", 2'b01, 8'h7F, 8'h00, 2'b01, 1'b0, 13'h0127, 13'h0127);
        convert("neg80", 2'b01, 8'h80, 8'h00, 2'b01, 1'b0, 13'h1128, 13'h0128);
        convert("negFF", 2'b01, 8'hFF, 8'h00, 2'b01, 1'b0, 13'h1001, 13'h0255);
        convert("zero",  2'b01, 8'h00, 8'h00, 2'b01, 1'b0, 13'h0000, 13'h0000);
        convert("req1C8", 2'b10, 8'h00, 8'hC8, 2'b10, 1'b1, 13'h1056, 13'h0200);

        // req1 arrives mid-conversion of req0 and waits for IDLE.
        req    = 2'b01;
        data_0 = 8'h2A;
        data_1 = 8'h63;
        tick;
        check("pend ack0", ack_s, 2'b01);
        req = 2'b00;
        repeat (3) tick;
        req = 2'b10;
        ok  = 1'b1;
        repeat (6) begin
            tick;
            if (ack_s !== 2'b00) ok = 1'b0;
        end
        check("pend no early ack", ok, 1);
        check("pend done0", done_s, 1);
        check("pend id0", done_id_s, 0);
        check("pend res0", res_s, 13'h0042);
        tick;
        check("pend ack1 at E10", ack_s, 2'b10);
        req = 2'b00;
        ok  = 1'b1;
        repeat (8) begin
            tick;
            if (res_s !== 13'h0042 || done_s !== 1'b0) ok = 1'b0;
        end
        check("pend res0 held", ok, 1);
        tick;
        check("pend done1", done_s, 1);
        check("pend id1", done_id_s, 1);
        check("pend res1", res_s, 13'h0099);
        tick;

        // Asynchronous reset during CONVERT.
        req    = 2'b01;
        data_0 = 8'h37;
        tick;
        check("rst ack", ack_s, 2'b01);
        req = 2'b00;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        check("async rst ctrl", {ack_s, busy_s, done_s, done_id_s}, 0);
        check("async rst res s", res_s, 0);
        check("async rst res u", res_u, 0);
        ok = 1'b1;
        repeat (3) begin
            tick;
            if (done_s !== 1'b0 || busy_s !== 1'b0) ok = 1'b0;
        end
        rst_n = 1'b1;
        repeat (10) begin
            tick;
            if (done_s !== 1'b0 || busy_s !== 1'b0) ok = 1'b0;
        end
        check("no done after rst", ok, 1);
        convert("after rst 05", 2'b01, 8'h05, 8'h00, 2'b01, 1'b0, 13'h0005, 13'h0005);

        for (int i = 0; i < 256; i++) begin
            convert($sformatf("sweep %02h", i), 2'b01, 8'(i), 8'h00, 2'b01, 1'b0,
                    ref_bcd(8'(i), 1'b1), ref_bcd(8'(i), 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
